rvc_fetch_aligner: RTL
======================

// Module: rvc_fetch_aligner
// PURPOSE
// - Sits between instruction fetch and decode. Accepts FETCH_W-bit fetch words and splits them into 16-bit parcels.
// - Realigns parcels into whole instructions, including 32-bit instructions that straddle two fetch words.
// - Expands RV32C parcels to RV32I through the rvc_expander sub-module.
// - Presents one registered 32-bit instruction per cycle on a valid/ready handshake.
// PARAMETERS
// - FETCH_W      32          fetch word width: 32 or 64 (2 or 4 parcels)
// - BUF_PARCELS  6           parcel buffer depth; must be >= FETCH_W/16 + 1
// - RESET_PC     32'h0       PC after reset (used only with RVC_PC_TRACK_EN)
// PORTS
// - clk          in   1        single clock, all logic rising-edge
// - rst_n        in   1        asynchronous, active-low reset
// - fetch_data   in   FETCH_W  fetch word, parcel 0 in bits [15:0]
// - fetch_valid  in   1        fetch_data valid
// - fetch_ready  out  1        buffer has room for FETCH_W/16 parcels (combinational from count)
// - flush        in   1        redirect: discard buffer, output register and pending skip
// - flush_pc     in   32       redirect target; bit[1] selects odd-halfword start
// - out_inst     out  32       RV32I instruction (expanded, or passed through if 32-bit)
// - out_is_rvc   out  1        out_inst came from a 16-bit parcel
// - out_illegal  out  1        parcel was illegal RVC (incl. 16'h0000); out_inst = {16'h0, parcel}
// - out_valid    out  1        output register holds an instruction
// - out_ready    in   1        decode accepts out_inst
// - out_pc       out  32       PC of out_inst (present only with RVC_PC_TRACK_EN)
// BEHAVIOUR
// - Reset values:
//   - out_valid=0; out_inst, out_is_rvc, out_illegal = 0.
//   - Buffer count=0; FSM=RUN.
//   - fetch_ready=1 one delta after reset; out_pc=RESET_PC.
// - Push: a fetch word is written when fetch_valid && fetch_ready && !flush.
// - FSM:
//   - RUN: all FETCH_W/16 parcels are written.
//   - SKIP: the lowest parcel is dropped on the next accepted word, then the FSM returns to RUN.
//   - flush with flush_pc[1]=1 enters SKIP; flush with flush_pc[1]=0 enters RUN.
// - Head classification: head[1:0]!=2'b11 is a 16-bit instruction (needs count>=1); otherwise it is 32-bit (needs count>=2).
// - Issue:
//   - A head instruction is complete and the output register is free or being drained (!out_valid || out_ready).
//   - The instruction is expanded and loaded into the output register, and 1 or 2 parcels are popped.
//   - Latency: 1 cycle from a complete head to out_valid.
//   - Throughput: 1 instruction per cycle.
// - Straddle: a 32-bit instruction with only its low parcel buffered waits; no output and no pop.
// - Simultaneous push and pop in the same cycle are legal. Count updates by +pushed-popped, and fetch_ready uses the pre-pop count.
// - Full: fetch_ready=0 while BUF_PARCELS-count < FETCH_W/16.
// - Out stall: while out_valid && !out_ready, all output fields hold stable.
// - Flush priority: flush beats push, issue and pop in the same cycle.
//   - Next cycle: count=0, out_valid=0.
//   - A word presented together with flush is dropped.
// - Illegal RVC (all-zero parcel, or any reserved/unsupported encoding) issues with out_illegal=1. It is never silently dropped.
// - Wrap: buffer is circular with head/tail pointers mod BUF_PARCELS. Pointers wrap without bubble.
// - Reset mid-operation: asynchronous clear to reset values. Any partially buffered instruction is lost.
// CONFIGURATION
// - Macro RVC_PC_TRACK_EN:
//   - Defined: adds out_pc and a PC register.
//   - The PC register loads flush_pc on flush and advances by 2 (RVC) or 4 on each out handshake.
//   - out_pc is registered with out_inst.
//   - Undefined: no out_pc port, no PC register, and RESET_PC is unused.
// STRUCTURE
// - Shared package RVC_Align_Pkg:
//   - parcel_t (16-bit);
//   - align_state_e {RUN, SKIP};
//   - PARCEL_W=16;
//   - function is_rvc(parcel).
// - RV32I opcode/funct constants come from the existing instruction packages.
// - Sub-module rvc_expander: purely combinational 16->32 expansion plus illegal flag, instantiated once on the head parcel.
// TESTING
// - FETCH_W=32, words 32'h4501_4581 (c.li a1,0; c.li a0,0):
//   - Expect 32'h0000_0593 then 32'h0000_0513 on consecutive cycles.
//   - out_is_rvc=1 for both.
// - Straddle: word0={16'h0513,16'h4581}, word1={16'h4501,16'h0000}:
//   - Expect c.li a1,0, then 32'h0000_0513 (out_is_rvc=0), then c.li a0,0.
//   - out_illegal=0 throughout.
// - Parcel 16'h0000:
//   - Expect out_illegal=1, out_inst=32'h0000_0000, out_valid=1.
// - Hold out_ready=0 for 10 cycles with fetch_valid=1:
//   - out fields stable, and fetch_ready falls once count>BUF_PARCELS-2.
//   - No parcel is lost after out_ready is released.
// - flush with flush_pc=32'h0000_0102 while buffer is half full:
//   - Next cycle out_valid=0, and the low parcel of the next word is skipped.
//   - out_pc=32'h102 with RVC_PC_TRACK_EN.
// - Assert rst_n=0 mid-straddle:
//   - Outputs are at reset values immediately, without waiting for clk.
//   - After release, the first full instruction issues correctly.

Source files
------------

// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared types and RV32I encoding constants for the RVC fetch aligner.
package RVC_Align_Pkg;

    localparam int PARCEL_W = 16;

    typedef logic [PARCEL_W-1:0] parcel_t;

    typedef enum logic {
        RUN  = 1'b0,
        SKIP = 1'b1
    } align_state_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    function automatic logic is_rvc(parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_fetch_aligner_if.sv
// Fetch/decode handshake bundle for the aligner.
// out_pc exists only when RVC_PC_TRACK_EN is defined.
interface rvc_fetch_aligner_if #(
    parameter int FETCH_W = 32
);
    logic [FETCH_W-1:0] fetch_data;
    logic               fetch_valid;
    logic               fetch_ready;
    logic               flush;
    logic [31:0]        flush_pc;
    logic [31:0]        out_inst;
    logic               out_is_rvc;
    logic               out_illegal;
    logic               out_valid;
    logic               out_ready;
`ifdef RVC_PC_TRACK_EN
    logic [31:0]        out_pc;
`endif

    modport slave (
`ifdef RVC_PC_TRACK_EN
        output out_pc,
`endif
        input  fetch_data, fetch_valid, flush, flush_pc, out_ready,
        output fetch_ready, out_inst, out_is_rvc, out_illegal, out_valid
    );

    modport master (
`ifdef RVC_PC_TRACK_EN
        input  out_pc,
`endif
        output fetch_data, fetch_valid, flush, flush_pc, out_ready,
        input  fetch_ready, out_inst, out_is_rvc, out_illegal, out_valid
    );

endinterface

// File: rtl/rvc_fetch_aligner_expander.sv
// Combinational RV32C -> RV32I expander with illegal-encoding flag.
module rvc_expander
    import RVC_Align_Pkg::*;
(
    input  parcel_t     parcel,
    output logic [31:0] inst,
    output logic        illegal
);
    logic [15:0] c;
    logic [4:0]  rd, rs2, rs1p, rdp;
    logic [2:0]  alu_f3;
    logic [31:0] exp;
    logic        bad;

    assign c      = parcel;
    assign rd     = c[11:7];
    assign rs2    = c[6:2];
    assign rs1p   = {2'b01, c[9:7]};
    assign rdp    = {2'b01, c[4:2]};
    assign alu_f3 = (c[6:5] == 2'b00) ? 3'b000 : {1'b1, c[6], c[6] & c[5]};

    always_comb begin
        exp = '0;
        bad = 1'b0;
        unique case ({c[1:0], c[15:13]})
            5'b00_000: begin
                exp = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b0,
                       5'd2, 3'b000, rdp, OP_IMM};
                bad = (c[12:5] == 8'h0);
            end
            5'b00_010: exp = {5'b0, c[5], c[12:10], c[6], 2'b0,
                              rs1p, 3'b010, rdp, OP_LOAD};
            5'b00_110: exp = {5'b0, c[5], c[12], rdp, rs1p, 3'b010,
                              c[11:10], c[6], 2'b0, OP_STORE};
            5'b01_000: exp = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, OP_IMM};
            5'b01_001, 5'b01_101: begin
                exp = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                       c[12], {8{c[12]}}, {4'b0, ~c[15]}, OP_JAL};
            end
            5'b01_010: exp = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, OP_IMM};
            5'b01_011: begin
                if (rd == 5'd2) begin
                    exp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0,
                           5'd2, 3'b000, 5'd2, OP_IMM};
                end else begin
                    exp = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI};
                end
                bad = ({c[12], c[6:2]} == 6'd0);
            end
            5'b01_100: begin
                unique case (c[11:10])
                    2'b00: begin
                        exp = {7'b0, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                        bad = c[12];
                    end
                    2'b01: begin
                        exp = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                        bad = c[12];
                    end
                    2'b10: exp = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, OP_IMM};
                    default: begin
                        exp = {(c[6:5] == 2'b00) ? 7'b0100000 : 7'b0,
                               rdp, rs1p, alu_f3, rs1p, OP_REG};
                        bad = c[12];
                    end
                endcase
            end
            5'b01_110, 5'b01_111: begin
                exp = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p,
                       {2'b00, c[13]}, c[11:10], c[4:3], c[12], OP_BRANCH};
            end
            5'b10_000: begin
                exp = {7'b0, c[6:2], rd, 3'b001, rd, OP_IMM};
                bad = c[12];
            end
            5'b10_010: begin
                exp = {4'b0, c[3:2], c[12], c[6:4], 2'b0, 5'd2, 3'b010, rd, OP_LOAD};
                bad = (rd == 5'd0);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        exp = {12'b0, rd, 3'b000, 5'd0, OP_JALR};
                        bad = (rd == 5'd0);
                    end else begin
                        exp = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
                    end
                end else if (rs2 == 5'd0) begin
                    exp = (rd == 5'd0) ? 32'h0010_0073
                                       : {12'b0, rd, 3'b000, 5'd1, OP_JALR};
                end else begin
                    exp = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
                end
            end
            5'b10_110: exp = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                              c[11:9], 2'b0, OP_STORE};
            default: bad = 1'b1;
        endcase
    end

    assign illegal = bad;
    assign inst    = bad ? {16'h0, c} : exp;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch-word to instruction aligner with RVC expansion.
// RVC_PC_TRACK_EN adds a PC register and the out_pc output.
module rvc_fetch_aligner
    import RVC_Align_Pkg::*;
#(
    parameter int          FETCH_W     = 32,
    parameter int          BUF_PARCELS = 6,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input logic                clk,
    input logic                rst_n,
    rvc_fetch_aligner_if.slave bus
);
    localparam int NP = FETCH_W / PARCEL_W;
    localparam int PW = $clog2(BUF_PARCELS);
    localparam int CW = $clog2(BUF_PARCELS + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    parcel_t      buffer [BUF_PARCELS];
    ptr_t         head, tail;
    cnt_t         count, n_push, n_pop;
    align_state_e state;
    parcel_t      h0, h1;
    logic         is32, complete, push, issue, skip_lo;
    logic [31:0]  exp_inst, out_inst;
    logic         exp_illegal, out_valid, out_is_rvc, out_illegal;

    function automatic ptr_t wrap(ptr_t p, int k);
        int s;
        s = int'(p) + k;
        return ptr_t'((s >= BUF_PARCELS) ? s - BUF_PARCELS : s);
    endfunction

    // PCs are halfword aligned; the buffer must hold a word plus a straddler
    always_comb assert (BUF_PARCELS >= NP + 1 && RESET_PC[0] == 1'b0);

    assign h0       = buffer[head];
    assign h1       = buffer[wrap(head, 1)];
    assign is32     = !is_rvc(h0);
    assign complete = is32 ? (count >= cnt_t'(2)) : (count != '0);
    assign skip_lo  = (state == SKIP);

    assign bus.fetch_ready = (BUF_PARCELS - int'(count)) >= NP;
    assign push  = bus.fetch_valid && bus.fetch_ready && !bus.flush;
    assign issue = complete && (!out_valid || bus.out_ready) && !bus.flush;

    assign n_push = push ? cnt_t'(skip_lo ? NP - 1 : NP) : '0;
    assign n_pop  = issue ? (is32 ? cnt_t'(2) : cnt_t'(1)) : '0;

    rvc_expander u_exp (
        .parcel  (h0),
        .inst    (exp_inst),
        .illegal (exp_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_PARCELS; i++) buffer[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < NP; i++) begin
                if (!(skip_lo && i == 0)) begin
                    buffer[wrap(tail, skip_lo ? i - 1 : i)] <=
                        bus.fetch_data[i*PARCEL_W +: PARCEL_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= bus.flush_pc[1] ? SKIP : RUN;
        end else begin
            if (push) begin
                tail <= wrap(tail, int'(n_push));
                if (skip_lo) state <= RUN;
            end
            if (issue) head <= wrap(head, int'(n_pop));
            count <= count + n_push - n_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_is_rvc  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_inst    <= is32 ? {h1, h0} : exp_inst;
            out_is_rvc  <= !is32;
            out_illegal <= !is32 && exp_illegal;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_inst    = out_inst;
    assign bus.out_is_rvc  = out_is_rvc;
    assign bus.out_illegal = out_illegal;

`ifdef RVC_PC_TRACK_EN
    logic [31:0] pc, out_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            out_pc <= RESET_PC;
        end else if (bus.flush) begin
            pc     <= bus.flush_pc;
            out_pc <= bus.flush_pc;
        end else if (issue) begin
            out_pc <= pc;
            pc     <= pc + (is32 ? 32'd4 : 32'd2);
        end
    end

    assign bus.out_pc = out_pc;
`endif

endmodule
